alu_seq: RTL and testbench

Operand sequencer and result checker on the initiator side of the 4-bit `alu` interface. Each run latches operands, an opcode and a mode at a `go` press, then drives registered `a`/`b`/`ctrl` into the combinational ALU. It captures `res`/`car`/`of` one cycle later and checks them against a built-in golden model. Sweep mode walks all 256 operand pairs for one opcode and accumulates flag and mismatch counts for on-board self-test.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_ref.sv | 54 +++++
 rtl/alu_seq.sv | 155 +++++++++++++++
 tb/tb_alu_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Purpose : shared opcodes and sequencer state type for the 4-bit ALU block.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_CMP = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_ref.sv
// Purpose : combinational golden model of the 4-bit ALU.
// Latency : 0 cycles (pure combinational).
// Backpr. : none.
// Ports   : a, b (operands), ctrl (opcode) in; res, car, of out.
module alu_ref
  import alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] ctrl,
  output logic [3:0] res,
  output logic       car,
  output logic       of
);

  logic [3:0] w_neg_b;
  logic [4:0] w_sum;

  always_comb begin
    w_neg_b = ~b + 4'd1;
    w_sum   = 5'd0;
    res     = 4'd0;
    car     = 1'b0;
    of      = 1'b0;
    case (ctrl)
      OP_ADD: begin
        w_sum = {1'b0, a} + {1'b0, b};
        res   = w_sum[3:0];
        car   = w_sum[4];
        of    = (a[3] == b[3]) && (w_sum[3] != a[3]);
      end
      OP_SUB: begin
        // Overflow intentionally compares against b's sign, not the negated b.
        w_sum = {1'b0, a} + {1'b0, w_neg_b};
        res   = w_sum[3:0];
        car   = w_sum[4];
        of    = (a[3] == b[3]) && (w_sum[3] != a[3]);
      end
      OP_NOT: res = ~a;
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_CMP: begin
        // Sign bits decide first; equal signs fall back to unsigned compare.
        if (!a[3] && b[3])      res = 4'd0;
        else if (a[3] && !b[3]) res = 4'd1;
        else                    res = (a < b) ? 4'd0 : 4'd1;
      end
      OP_EQ:  res = (a == b) ? 4'd0 : 4'd1;
      default: res = 4'd0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Purpose : operand sequencer + result checker driving a 4-bit combinational ALU.
// Latency : single run: done 1 cycle after start; sweep: done 256 cycles after start.
// Backpr. : none; go is ignored while a run is in progress.
// Ports   : clk/rst; go, mode, sw_a/sw_b/sw_ctrl (run request); alu_a/alu_b/alu_ctrl out and
//           alu_res/alu_car/alu_of in (ALU link); res_q/car_q/of_q, busy, done,
//           car_cnt/of_cnt/err_cnt, err_seen, err_first (run status and self-test results).
module alu_seq
  import alu_pkg::*;
#(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             mode,
  input  logic [3:0]       sw_a,
  input  logic [3:0]       sw_b,
  input  logic [2:0]       sw_ctrl,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [3:0]       alu_res,
  input  logic             alu_car,
  input  logic             alu_of,
  output logic [3:0]       res_q,
  output logic             car_q,
  output logic             of_q,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] car_cnt,
  output logic [CNT_W-1:0] of_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_seen,
  output logic [7:0]       err_first
);

  seq_state_t       r_state;
  seq_state_t       w_nxt_state;
  logic             r_go_d;
  logic             r_mode;
  logic [3:0]       r_a;
  logic [3:0]       r_b;
  logic [2:0]       r_ctrl;
  logic [3:0]       r_res;
  logic             r_car;
  logic             r_of;
  logic [CNT_W-1:0] r_car_cnt;
  logic [CNT_W-1:0] r_of_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_err_seen;
  logic [7:0]       r_err_first;

  logic             w_start;
  logic             w_last;
  logic             w_mis;
  logic [3:0]       w_ref_res;
  logic             w_ref_car;
  logic             w_ref_of;

  alu_ref u_ref (
    .a    (r_a),
    .b    (r_b),
    .ctrl (r_ctrl),
    .res  (w_ref_res),
    .car  (w_ref_car),
    .of   (w_ref_of)
  );

  assign w_last = (r_a == 4'hF) && (r_b == 4'hF);
  assign w_mis  = (alu_res != w_ref_res) || (alu_car != w_ref_car) || (alu_of != w_ref_of);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    w_start     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (go && !r_go_d) begin
          w_start     = 1'b1;
          w_nxt_state = ST_DRIVE;
        end
      end
      ST_DRIVE: if (!r_mode || w_last) w_nxt_state = ST_DONE;
      ST_DONE:  w_nxt_state = ST_IDLE;
      default:  w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // go_d resets high so a go held through reset release is not a start.
      r_go_d      <= 1'b1;
      r_mode      <= 1'b0;
      r_a         <= 4'd0;
      r_b         <= 4'd0;
      r_ctrl      <= 3'd0;
      r_res       <= 4'd0;
      r_car       <= 1'b0;
      r_of        <= 1'b0;
      r_car_cnt   <= '0;
      r_of_cnt    <= '0;
      r_err_cnt   <= '0;
      r_err_seen  <= 1'b0;
      r_err_first <= 8'd0;
    end else begin
      r_go_d <= go;
      if (w_start) begin
        r_mode      <= mode;
        r_ctrl      <= sw_ctrl;
        r_a         <= mode ? 4'd0 : sw_a;
        r_b         <= mode ? 4'd0 : sw_b;
        r_car_cnt   <= '0;
        r_of_cnt    <= '0;
        r_err_cnt   <= '0;
        r_err_seen  <= 1'b0;
        r_err_first <= 8'd0;
      end else if (r_state == ST_DRIVE) begin
        r_res <= alu_res;
        r_car <= alu_car;
        r_of  <= alu_of;
        if (alu_car) r_car_cnt <= r_car_cnt + CNT_W'(1);
        if (alu_of)  r_of_cnt  <= r_of_cnt + CNT_W'(1);
        if (w_mis) begin
          r_err_cnt <= r_err_cnt + CNT_W'(1);
          if (!r_err_seen) begin
            r_err_seen  <= 1'b1;
            r_err_first <= {r_a, r_b};
          end
        end
        // b is the inner loop: one 8-bit increment carries b's wrap into a.
        // Operands hold at (15,15) once the final pair has been captured.
        if (r_mode && !w_last) {r_a, r_b} <= {r_a, r_b} + 8'd1;
      end
    end
  end

  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_ctrl  = r_ctrl;
  assign res_q     = r_res;
  assign car_q     = r_car;
  assign of_q      = r_of;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign car_cnt   = r_car_cnt;
  assign of_cnt    = r_of_cnt;
  assign err_cnt   = r_err_cnt;
  assign err_seen  = r_err_seen;
  assign err_first = r_err_first;

endmodule

// File: tb/tb_alu_seq.sv
// Purpose : self-checking bench for alu_seq with a behavioural ALU and run-timeline model.
// Latency : n/a.
// Backpr. : n/a.
module tb_alu_seq;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       go = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] sw_a = 4'd0;
  logic [3:0] sw_b = 4'd0;
  logic [2:0] sw_ctrl = 3'd0;
  logic [3:0] alu_a, alu_b, alu_res, res_q;
  logic [2:0] alu_ctrl;
  logic       alu_car, alu_of, car_q, of_q, busy, done, err_seen;
  logic [8:0] car_cnt, of_cnt, err_cnt;
  logic [7:0] err_first;

  logic fault = 1'b0;    // force ALU result to 0
  logic disturb = 1'b0;  // wiggle go/sw_* during a run

  int n_chk = 0;
  int n_fail = 0;

  alu_seq #(.CNT_W(9)) dut (
    .clk(clk), .rst(rst), .go(go), .mode(mode), .sw_a(sw_a), .sw_b(sw_b), .sw_ctrl(sw_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_res(alu_res), .alu_car(alu_car), .alu_of(alu_of),
    .res_q(res_q), .car_q(car_q), .of_q(of_q), .busy(busy), .done(done),
    .car_cnt(car_cnt), .of_cnt(of_cnt), .err_cnt(err_cnt),
    .err_seen(err_seen), .err_first(err_first)
  );

  always #5 clk = ~clk;

  // Golden ALU written in integer arithmetic; returns {car, of, res}.
  function automatic logic [5:0] golden(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] op);
    int ia, ib, s, r;
    logic c, o;
    ia = int'(a); ib = int'(b); s = 0; r = 0; c = 1'b0; o = 1'b0;
    case (op)
      3'd0, 3'd1: begin
        s = (op == 3'd0) ? ia + ib : ia + ((16 - ib) % 16);
        r = s % 16;
        c = (s > 15);
        o = ((ia >= 8) == (ib >= 8)) && ((r >= 8) != (ia >= 8));
      end
      3'd2: r = 15 - ia;
      3'd3: r = ia & ib;
      3'd4: r = ia | ib;
      3'd5: r = ia ^ ib;
      3'd6: begin
        if (ia < 8 && ib >= 8)      r = 0;
        else if (ia >= 8 && ib < 8) r = 1;
        else                        r = (ia < ib) ? 0 : 1;
      end
      default: r = (ia == ib) ? 0 : 1;
    endcase
    return {c, o, r[3:0]};
  endfunction

  // Bench-side ALU answering the DUT's drive.
  logic [5:0] alu_g;
  always_comb begin
    alu_g   = golden(alu_a, alu_b, alu_ctrl);
    alu_res = fault ? 4'd0 : alu_g[3:0];
    alu_car = alu_g[5];
    alu_of  = alu_g[4];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural run-timeline model ----------------
  int   e = 0, k = 0, len = 1;
  bit   m_act = 0, m_go_d = 1;
  int   m_sa = 0, m_sb = 0, m_ctrl = 0;
  int   x_a = 0, x_b = 0, x_ctrl = 0, x_res = 0, x_car = 0, x_of = 0;
  int   x_busy = 0, x_done = 0, x_carc = 0, x_ofc = 0, x_errc = 0, x_seen = 0, x_first = 0;
  bit   x_alu_chk = 1;

  // Operand pair n of the current run.
  function automatic int pa(input int n);
    return (len == 1) ? m_sa : n / 16;
  endfunction
  function automatic int pb(input int n);
    return (len == 1) ? m_sb : n % 16;
  endfunction

  always @(posedge clk) begin
    int d;
    logic [5:0] g;
    int got;
    e++;
    if (rst) begin
      m_act = 0; m_go_d = 1; x_alu_chk = 1;
      x_a = 0; x_b = 0; x_ctrl = 0; x_res = 0; x_car = 0; x_of = 0; x_busy = 0; x_done = 0;
      x_carc = 0; x_ofc = 0; x_errc = 0; x_seen = 0; x_first = 0;
    end else begin
      if ((!m_act || e >= k + len + 2) && go && !m_go_d) begin
        m_act = 1; k = e; len = mode ? 256 : 1;
        m_sa = int'(sw_a); m_sb = int'(sw_b); m_ctrl = int'(sw_ctrl);
        x_ctrl = m_ctrl; x_carc = 0; x_ofc = 0; x_errc = 0; x_seen = 0; x_first = 0;
      end
      m_go_d = go;
      if (m_act) begin
        d = e - k;
        if (d >= 1 && d <= len) begin
          g = golden(4'(pa(d - 1)), 4'(pb(d - 1)), 3'(m_ctrl));
          got = fault ? 0 : int'(g[3:0]);
          x_res = got; x_car = int'(g[5]); x_of = int'(g[4]);
          x_carc += x_car; x_ofc += x_of;
          if (got != int'(g[3:0])) begin
            x_errc++;
            if (x_seen == 0) begin x_seen = 1; x_first = pa(d - 1) * 16 + pb(d - 1); end
          end
        end
        if (d < len) begin x_alu_chk = 1; x_a = pa(d); x_b = pb(d); end
        else x_alu_chk = 0;
        x_busy = (d <= len) ? 1 : 0;
        x_done = (d == len) ? 1 : 0;
      end
    end
  end

  // Cycle-by-cycle compare, 1 time unit after each active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("busy", int'(busy), x_busy);
      chk("done", int'(done), x_done);
      chk("res_q", int'(res_q), x_res);
      chk("car_q", int'(car_q), x_car);
      chk("of_q", int'(of_q), x_of);
      chk("car_cnt", int'(car_cnt), x_carc);
      chk("of_cnt", int'(of_cnt), x_ofc);
      chk("err_cnt", int'(err_cnt), x_errc);
      chk("err_seen", int'(err_seen), x_seen);
      chk("err_first", int'(err_first), x_first);
      if (x_alu_chk) begin
        chk("alu_a", int'(alu_a), x_a);
        chk("alu_b", int'(alu_b), x_b);
        chk("alu_ctrl", int'(alu_ctrl), x_ctrl);
      end
    end
  end

  // Press go for one cycle and wait (bounded) for done; lat = negedges until done seen.
  task automatic run(input logic m, input logic [3:0] a, input logic [3:0] b,
                     input logic [2:0] op, output int lat);
    @(negedge clk);
    mode = m; sw_a = a; sw_b = b; sw_ctrl = op; go = 1'b1;
    lat = 0;
    while (!done && lat < 400) begin
      @(negedge clk);
      lat++;
      if (disturb) begin
        go = ((lat >= 50 && lat < 55) || (lat >= 120 && lat < 122));
        sw_a = 4'($urandom); sw_ctrl = 3'($urandom); mode = 1'($urandom);
      end else begin
        go = 1'b0;
      end
    end
    chk("run_done_seen", int'(done), 1);
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
    chk("idle_after_done", int'(busy), 0);
  endtask

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_alu_a", int'(alu_a), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run(1'b0, 4'd7, 4'd1, OP_ADD, lat);
    chk("add_lat", lat, 2);
    chk("add_res", int'(res_q), 8);
    chk("add_car", int'(car_q), 0);
    chk("add_of", int'(of_q), 1);
    chk("add_err", int'(err_cnt), 0);

    run(1'b0, 4'd3, 4'd5, OP_SUB, lat);
    chk("sub_res", int'(res_q), 14);
    chk("sub_car", int'(car_q), 0);
    chk("sub_of", int'(of_q), 1);
    chk("sub_err", int'(err_cnt), 0);

    run(1'b1, 4'd0, 4'd0, OP_ADD, lat);
    chk("sweep_lat", lat, 257);
    chk("sweep_car_cnt", int'(car_cnt), 120);
    chk("sweep_of_cnt", int'(of_cnt), 64);
    chk("sweep_err_cnt", int'(err_cnt), 0);

    fault = 1'b1;
    run(1'b1, 4'd0, 4'd0, OP_EQ, lat);
    fault = 1'b0;
    chk("eq_err_cnt", int'(err_cnt), 240);
    chk("eq_err_seen", int'(err_seen), 1);
    chk("eq_err_first", int'(err_first), 8'h01);

    for (int i = 0; i < 24; i++) begin
      fault = 1'($urandom_range(3) == 0);
      run(1'b0, 4'($urandom), 4'($urandom), 3'($urandom), lat);
    end
    for (int i = 0; i < 2; i++) begin
      fault = 1'($urandom);
      run(1'b1, 4'($urandom), 4'($urandom), 3'($urandom), lat);
    end
    fault = 1'b0;

    // Reset in the middle of a sweep with go held high across release.
    @(negedge clk);
    mode = 1'b1; sw_ctrl = OP_ADD; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (100) @(negedge clk);
    go = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_car_cnt", int'(car_cnt), 0);
    chk("midrst_alu_b", int'(alu_b), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("no_start_held_go", int'(busy), 0);
    go = 1'b0;
    run(1'b1, 4'd0, 4'd0, OP_ADD, lat);
    chk("post_rst_lat", lat, 257);
    chk("post_rst_car_cnt", int'(car_cnt), 120);

    // Disturbed sweep must match an undisturbed one.
    disturb = 1'b1;
    run(1'b1, 4'd0, 4'd0, OP_ADD, lat);
    disturb = 1'b0;
    go = 1'b0;
    chk("dist_lat", lat, 257);
    chk("dist_car_cnt", int'(car_cnt), 120);
    chk("dist_of_cnt", int'(of_cnt), 64);
    chk("dist_err_cnt", int'(err_cnt), 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
